// File: rtl/axis_ic_pkg.sv
// Shared definitions for the AXI-Stream interconnect family (S2M / M2S).
package axis_ic_pkg;

    // Packet-tracking states: HEAD expects the first beat of a packet.
    typedef enum logic {
        HEAD = 1'b0,
        BODY = 1'b1
    } pkt_state_e;

    // Width of a port index for NUM ports (1..32).
    function automatic int nsize(input int num);
        return (num <= 2) ? 1 : (num <= 4) ? 2 : (num <= 8) ? 3 : (num <= 16) ? 4 : 5;
    endfunction

endpackage

// File: rtl/axi_stream_skid_reg.sv
// Two-entry registered valid/ready stage. Both the payload and in_ready come
// from flops, so neither path is combinational from the far side.
module axi_stream_skid_reg #(
    parameter int DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [DSIZE-1:0] main_data;
    logic [DSIZE-1:0] skid_data;
    logic             main_valid;
    logic             skid_valid;
    logic             acc;
    logic             drain;

    assign in_ready  = ~skid_valid & en;
    assign acc       = in_valid & in_ready;
    assign drain     = main_valid & out_ready & en;
    assign out_data  = main_data;
    assign out_valid = main_valid;

    // Main register refills from skid first (ordering), else straight from input;
    // skid only catches a beat while main is stalled.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            main_data  <= '0;
            skid_data  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (en) begin
            if (!main_valid || drain) begin
                if (skid_valid) begin
                    main_data  <= skid_data;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= acc;
                    if (acc) main_data <= in_data;
                end
            end else if (acc) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_stream_interconnect_s2m_pkt.sv
// Packet-routing AXI-Stream demux: one slave fanned out to NUM masters.
// Destination is latched from addr on the head beat and held until tlast;
// packets addressed at or beyond NUM are swallowed.
module axi_stream_interconnect_s2m_pkt
    import axis_ic_pkg::*;
#(
    parameter  int NUM   = 8,
    parameter  int DSIZE = 8,
    parameter  int KSIZE = 1,
    parameter  int USIZE = 1,
    localparam int NSIZE = nsize(NUM)
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic [NSIZE-1:0]           addr,
    input  logic [DSIZE-1:0]           s00_tdata,
    input  logic                       s00_tvalid,
    output logic                       s00_tready,
    input  logic                       s00_tlast,
    input  logic [USIZE-1:0]           s00_tuser,
    input  logic [KSIZE-1:0]           s00_tkeep,
    output logic [NUM-1:0][DSIZE-1:0]  m00_tdata,
    output logic [NUM-1:0]             m00_tvalid,
    input  logic [NUM-1:0]             m00_tready,
    output logic [NUM-1:0]             m00_tlast,
    output logic [NUM-1:0][USIZE-1:0]  m00_tuser,
    output logic [NUM-1:0][KSIZE-1:0]  m00_tkeep,
    output logic                       drop_pulse
);

    localparam int           PW    = KSIZE + USIZE + 1 + DSIZE + NSIZE;
    localparam logic [NSIZE:0] NUM_W = (NSIZE+1)'(NUM);

    pkt_state_e       state_q, state_d;
    logic [NSIZE-1:0] cur_dest;
    logic [NSIZE-1:0] dest;
    logic             acc;
    logic [PW-1:0]    in_pld, out_pld;
    logic             main_valid, main_ready, main_oor;
    logic [NSIZE-1:0] main_dest;
    logic [DSIZE-1:0] main_data;
    logic             main_last;
    logic [USIZE-1:0] main_user;
    logic [KSIZE-1:0] main_keep;
    logic [NUM-1:0]   sel;

    assign acc = s00_tvalid & s00_tready;

    // Head beat routes by addr; body beats follow the latched destination.
    always_comb begin
        state_d = state_q;
        dest    = (state_q == HEAD) ? addr : cur_dest;
        if (acc) begin
            case (state_q)
                HEAD:    if (!s00_tlast) state_d = BODY;
                BODY:    if (s00_tlast)  state_d = HEAD;
                default: state_d = HEAD;
            endcase
        end
    end

    // Packet state, latched destination and the head-of-dropped-packet pulse.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HEAD;
            cur_dest   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (acc && state_q == HEAD) cur_dest <= addr;
            drop_pulse <= acc && (state_q == HEAD) && ({1'b0, addr} >= NUM_W);
        end
    end

    assign in_pld = {s00_tkeep, s00_tuser, s00_tlast, s00_tdata, dest};

    axi_stream_skid_reg #(.DSIZE(PW)) u_skid (
        .clock     (clock),
        .rst_n     (rst_n),
        .en        (clk_en),
        .in_data   (in_pld),
        .in_valid  (s00_tvalid),
        .in_ready  (s00_tready),
        .out_data  (out_pld),
        .out_valid (main_valid),
        .out_ready (main_ready)
    );

    assign {main_keep, main_user, main_last, main_data, main_dest} = out_pld;

    // Out-of-range beats drain unconditionally, which discards them.
    assign main_oor   = ({1'b0, main_dest} >= NUM_W);
    assign main_ready = main_oor | (|(sel & m00_tready));

    // Per-port select decode and valid demux; payload is broadcast.
    for (genvar i = 0; i < NUM; i++) begin : g_port
        assign sel[i]        = (main_dest == NSIZE'(i));
        assign m00_tvalid[i] = main_valid & sel[i] & clk_en;
        assign m00_tdata[i]  = main_data;
        assign m00_tlast[i]  = main_last;
        assign m00_tuser[i]  = main_user;
        assign m00_tkeep[i]  = main_keep;
    end

endmodule

// File: tb/tb_axi_stream_interconnect_s2m_pkt.sv
// Directed bench for the S2M packet demux (NUM=5 so out-of-range addrs exist).
module tb_axi_stream_interconnect_s2m_pkt;

    localparam int NUM   = 5;
    localparam int DSIZE = 8;
    localparam int KSIZE = 1;
    localparam int USIZE = 1;
    localparam int NSIZE = 3;

    logic                      clock = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      clk_en = 1'b1;
    logic [NSIZE-1:0]          addr = '0;
    logic [DSIZE-1:0]          s00_tdata = '0;
    logic                      s00_tvalid = 1'b0;
    logic                      s00_tready;
    logic                      s00_tlast = 1'b0;
    logic [USIZE-1:0]          s00_tuser = '0;
    logic [KSIZE-1:0]          s00_tkeep = '0;
    logic [NUM-1:0][DSIZE-1:0] m00_tdata;
    logic [NUM-1:0]            m00_tvalid;
    logic [NUM-1:0]            m00_tready = '1;
    logic [NUM-1:0]            m00_tlast;
    logic [NUM-1:0][USIZE-1:0] m00_tuser;
    logic [NUM-1:0][KSIZE-1:0] m00_tkeep;
    logic                      drop_pulse;

    int n_cmp = 0;
    int n_err = 0;

    axi_stream_interconnect_s2m_pkt #(
        .NUM(NUM), .DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .addr       (addr),
        .s00_tdata  (s00_tdata),
        .s00_tvalid (s00_tvalid),
        .s00_tready (s00_tready),
        .s00_tlast  (s00_tlast),
        .s00_tuser  (s00_tuser),
        .s00_tkeep  (s00_tkeep),
        .m00_tdata  (m00_tdata),
        .m00_tvalid (m00_tvalid),
        .m00_tready (m00_tready),
        .m00_tlast  (m00_tlast),
        .m00_tuser  (m00_tuser),
        .m00_tkeep  (m00_tkeep),
        .drop_pulse (drop_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a, input logic l);
        s00_tvalid = v;
        s00_tdata  = d;
        addr       = a;
        s00_tlast  = l;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int       t2_dat[4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    int       t2_adr[4] = '{0, 1, 3, 0};
    int       t2_vld[4] = '{5'b00001, 5'b00010, 5'b01000, 5'b00001};
    int       t3_idx[11] = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7};
    bit       t3_snk[11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int       t3_dat[11] = '{0, 1, 1, 1, 1, 2, 3, 4, 5, 6, 7};
    bit       t3_rdy[11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_vld",   m00_tvalid, 0);
        chk("rst_data",  m00_tdata, 0);
        chk("rst_last",  m00_tlast, 0);
        chk("rst_keep",  m00_tkeep, 0);
        chk("rst_drop",  drop_pulse, 0);
        chk("rst_rdy",   s00_tready, 1);
        @(negedge clock);
        rst_n = 1'b1;

        // 3-beat packet to port 2; addr changes mid-packet and must be ignored
        s00_tkeep = 1'b1;
        s00_tuser = 1'b1;
        drive(1, 8'h11, 2, 0); tick();
        chk("t1_b0_vld",  m00_tvalid, 5'b00100);
        chk("t1_b0_data", m00_tdata[2], 8'h11);
        chk("t1_b0_keep", m00_tkeep[2], 1);
        chk("t1_b0_user", m00_tuser[2], 1);
        drive(1, 8'h22, 0, 0); tick();
        chk("t1_b1_vld",  m00_tvalid, 5'b00100);
        chk("t1_b1_data", m00_tdata[2], 8'h22);
        chk("t1_b1_last", m00_tlast[2], 0);
        drive(1, 8'h33, 0, 1); tick();
        chk("t1_b2_vld",  m00_tvalid, 5'b00100);
        chk("t1_b2_data", m00_tdata[2], 8'h33);
        chk("t1_b2_last", m00_tlast[2], 1);
        chk("t1_b2_rdy",  s00_tready, 1);
        s00_tkeep = 1'b0;
        s00_tuser = 1'b0;
        drive(0, 8'h00, 0, 0); tick();
        chk("t1_idle_vld", m00_tvalid, 0);

        // Back-to-back single-beat packets
        for (int k = 0; k < 4; k++) begin
            drive(1, 8'(t2_dat[k]), 3'(t2_adr[k]), 1); tick();
            chk($sformatf("t2_vld%0d", k),  m00_tvalid, 64'(t2_vld[k]));
            chk($sformatf("t2_data%0d", k), m00_tdata[t2_adr[k]], 64'(t2_dat[k]));
            chk($sformatf("t2_rdy%0d", k),  s00_tready, 1);
        end
        drive(0, 8'h00, 0, 0); tick();
        chk("t2_idle_vld", m00_tvalid, 0);

        // 8-beat stream to port 1 with a 3-cycle sink stall
        for (int k = 0; k < 11; k++) begin
            drive(1, 8'(8'hB0 + t3_idx[k]), 1, t3_idx[k] == 7);
            m00_tready[1] = t3_snk[k];
            tick();
            chk($sformatf("t3_vld%0d", k),  m00_tvalid, 5'b00010);
            chk($sformatf("t3_data%0d", k), m00_tdata[1], 64'(8'hB0 + t3_dat[k]));
            chk($sformatf("t3_rdy%0d", k),  s00_tready, 64'(t3_rdy[k]));
        end
        chk("t3_last", m00_tlast[1], 1);
        drive(0, 8'h00, 0, 0); tick();
        chk("t3_idle_vld", m00_tvalid, 0);

        // Out-of-range packet (addr 6) is swallowed; body addr is ignored
        drive(1, 8'hC0, 6, 0); tick();
        chk("t4_c0_drop", drop_pulse, 1);
        chk("t4_c0_vld",  m00_tvalid, 0);
        chk("t4_c0_rdy",  s00_tready, 1);
        drive(1, 8'hC1, 1, 0); tick();
        chk("t4_c1_drop", drop_pulse, 0);
        chk("t4_c1_vld",  m00_tvalid, 0);
        chk("t4_c1_rdy",  s00_tready, 1);
        drive(1, 8'hC2, 1, 0); tick();
        chk("t4_c2_vld",  m00_tvalid, 0);
        drive(1, 8'hC3, 1, 1); tick();
        chk("t4_c3_vld",  m00_tvalid, 0);
        chk("t4_c3_drop", drop_pulse, 0);
        drive(1, 8'hD0, 4, 1); tick();
        chk("t4_d0_vld",  m00_tvalid, 5'b10000);
        chk("t4_d0_data", m00_tdata[4], 8'hD0);
        chk("t4_d0_drop", drop_pulse, 0);
        drive(0, 8'h00, 0, 0); tick();
        chk("t4_idle_vld", m00_tvalid, 0);

        // Reset mid-packet, then a new head routes by addr
        drive(1, 8'hE0, 3, 0); tick();
        drive(1, 8'hE1, 1, 0); tick();
        chk("t5_e1_vld",  m00_tvalid, 5'b01000);
        chk("t5_e1_data", m00_tdata[3], 8'hE1);
        drive(1, 8'hE2, 3, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_vld",  m00_tvalid, 0);
        chk("t5_async_data", m00_tdata[3], 0);
        drive(0, 8'h00, 0, 0);
        @(negedge clock);
        rst_n = 1'b1;
        drive(1, 8'hF0, 1, 1); tick();
        chk("t5_f0_vld",  m00_tvalid, 5'b00010);
        chk("t5_f0_data", m00_tdata[1], 8'hF0);
        drive(0, 8'h00, 0, 0); tick();
        chk("t5_idle_vld", m00_tvalid, 0);

        // clk_en low for 3 cycles mid-packet
        drive(1, 8'h60, 2, 0); tick();
        chk("t6_g0_vld", m00_tvalid, 5'b00100);
        clk_en = 1'b0;
        drive(1, 8'h61, 4, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t6_hold_vld%0d", k),  m00_tvalid, 0);
            chk($sformatf("t6_hold_rdy%0d", k),  s00_tready, 0);
            chk($sformatf("t6_hold_data%0d", k), m00_tdata[2], 8'h60);
        end
        clk_en = 1'b1;
        #1;
        chk("t6_resume_vld", m00_tvalid, 5'b00100);
        tick();
        chk("t6_g1_vld",  m00_tvalid, 5'b00100);
        chk("t6_g1_data", m00_tdata[2], 8'h61);
        drive(1, 8'h62, 0, 1); tick();
        chk("t6_g2_vld",  m00_tvalid, 5'b00100);
        chk("t6_g2_data", m00_tdata[2], 8'h62);
        chk("t6_g2_last", m00_tlast[2], 1);
        drive(0, 8'h00, 0, 0); tick();
        chk("t6_idle_vld", m00_tvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
